// File: rtl/h264invdctransform_chroma_if.sv
// Handshake bundle for the inverse chroma DC path: block input (READYI/ENABLE)
// and term output (VALID/READYO).
interface h264invdctransform_chroma_if;
    logic               READYI;
    logic               ENABLE;
    logic signed [15:0] XXIN;
    logic [5:0]         QP;
    logic               VALID;
    logic signed [15:0] YYOUT;
    logic               READYO;

    modport master (
        input  READYI, VALID, YYOUT,
        output ENABLE, XXIN, QP, READYO
    );

    modport slave (
        output READYI, VALID, YYOUT,
        input  ENABLE, XXIN, QP, READYO
    );
endinterface

// File: rtl/h264invdctransform_chroma.sv
// Inverse 2x2 chroma DC Hadamard followed by flat-matrix DC dequantisation.
// Four levels in, four saturated 16-bit terms out, READYO-paced.
module h264invdctransform_chroma #(
    parameter bit TOGETHER = 1'b0
) (
    input  logic                        CLK2,
    input  logic                        RESET,
    h264invdctransform_chroma_if.slave  bus
);
    logic               enablei_q, enablei_d;
    logic signed [15:0] xxii_q, xxii_d;
    logic [5:0]         qpi_q, qpi_d;
    logic [1:0]         icnt_q, icnt_d;
    logic [1:0]         ocnt_q, ocnt_d;
    logic               busy_q, busy_d;
    logic [5:0]         qp_q, qp_d;
    logic signed [16:0] r0_q, r0_d, r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
    logic signed [17:0] fa_q, fa_d;
    logic [5:0]         qa_q, qa_d;
    logic               va_q, va_d;
    logic               vb_q, vb_d;
    logic signed [15:0] yy_q, yy_d;

    logic signed [16:0] xs;
    logic               fire;
    logic [3:0]         qdiv;
    logic [5:0]         qrem;
    logic [4:0]         vmul;
    logic signed [22:0] prod;
    logic signed [31:0] shl;
    logic signed [31:0] half;

    assign xs   = {xxii_q[15], xxii_q};
    assign fire = busy_q && (bus.READYO || (TOGETHER && (ocnt_q != 2'd0)));

    // Input capture and row butterflies; while busy the r* registers belong to the sequencer.
    always_comb begin
        enablei_d = bus.ENABLE;
        xxii_d    = bus.XXIN;
        qpi_d     = bus.QP;
        icnt_d    = icnt_q;
        ocnt_d    = ocnt_q;
        busy_d    = busy_q;
        qp_d      = qp_q;
        r0_d      = r0_q;
        r1_d      = r1_q;
        r2_d      = r2_q;
        r3_d      = r3_q;
        fa_d      = fa_q;
        qa_d      = qa_q;
        va_d      = fire;
        if (enablei_q && !busy_q) begin
            icnt_d = icnt_q + 2'd1;
            case (icnt_q)
                2'd0: begin
                    r0_d = xs;
                    qp_d = (qpi_q > 6'd51) ? 6'd51 : qpi_q;
                end
                2'd1: begin
                    r0_d = r0_q + xs;
                    r1_d = r0_q - xs;
                end
                2'd2: r2_d = xs;
                default: begin
                    r2_d   = r2_q + xs;
                    r3_d   = r2_q - xs;
                    busy_d = 1'b1;
                end
            endcase
        end
        if (fire) begin
            ocnt_d = ocnt_q + 2'd1;
            qa_d   = qp_q;
            case (ocnt_q)
                2'd0: fa_d = 18'(r0_q) + 18'(r2_q);
                2'd1: fa_d = 18'(r1_q) + 18'(r3_q);
                2'd2: fa_d = 18'(r0_q) - 18'(r2_q);
                default: begin
                    fa_d   = 18'(r1_q) - 18'(r3_q);
                    busy_d = 1'b0;
                end
            endcase
        end
    end

    // Dequant: qp/6 by compare chain, qp%6 selects the DC scale.
    always_comb begin
        qdiv = 4'd0;
        for (int k = 1; k <= 8; k++) begin
            if (qa_q >= 6'(6 * k)) qdiv = 4'(k);
        end
        qrem = qa_q - 6'(qdiv * 6);
        case (qrem)
            6'd1:    vmul = 5'd11;
            6'd2:    vmul = 5'd13;
            6'd3:    vmul = 5'd14;
            6'd4:    vmul = 5'd16;
            6'd5:    vmul = 5'd18;
            default: vmul = 5'd10;
        endcase
        prod = $signed({{5{fa_q[17]}}, fa_q}) * $signed({18'd0, vmul});
        shl  = $signed({{9{prod[22]}}, prod}) <<< qdiv;
        half = shl >>> 1;
        vb_d = va_q;
        yy_d = yy_q;
        if (va_q) begin
            if (half > 32767)       yy_d = 16'sh7fff;
            else if (half < -32768) yy_d = -16'sh8000;
            else                    yy_d = half[15:0];
        end
    end

    always_ff @(posedge CLK2 or posedge RESET) begin
        if (RESET) begin
            enablei_q <= 1'b0;
            icnt_q    <= 2'd0;
            ocnt_q    <= 2'd0;
            busy_q    <= 1'b0;
            va_q      <= 1'b0;
            vb_q      <= 1'b0;
            yy_q      <= 16'sd0;
        end else begin
            enablei_q <= enablei_d;
            icnt_q    <= icnt_d;
            ocnt_q    <= ocnt_d;
            busy_q    <= busy_d;
            va_q      <= va_d;
            vb_q      <= vb_d;
            yy_q      <= yy_d;
        end
    end

    always_ff @(posedge CLK2) begin
        xxii_q <= xxii_d;
        qpi_q  <= qpi_d;
        qp_q   <= qp_d;
        r0_q   <= r0_d;
        r1_q   <= r1_d;
        r2_q   <= r2_d;
        r3_q   <= r3_d;
        fa_q   <= fa_d;
        qa_q   <= qa_d;
    end

    assign bus.READYI = !busy_q;
    assign bus.VALID  = vb_q;
    assign bus.YYOUT  = yy_q;
endmodule

// File: doc/h264invdctransform_chroma.md
Name: h264invdctransform_chroma

Overview:
Inverse 2x2 chroma DC path for the reconstruction (decode) side of the encoder. It takes 4 quantised chroma DC levels in raster order, applies the 2x2 Hadamard inverse transform, then dequantises with the H.264 flat-matrix chroma DC rule. It feeds the inverse 4x4 core transform that rebuilds the chroma reference. The input/output handshake is the same READYI/ENABLE/VALID/READYO scheme used by the forward DC transform.

Parameters:
TOGETHER, 0, 1 = once the first output term is emitted, the remaining 3 terms are emitted on consecutive cycles regardless of READYO.

Ports:
CLK2  in  1  fast clock; all logic on rising edge
RESET  in  1  asynchronous, active-high reset
READYI  out  1  combinational; high when a new block may be input (= not busy)
ENABLE  in  1  XXIN (and QP on the first coefficient) are valid this cycle
XXIN  in  16  signed quantised DC level; order c00, c01, c10, c11
QP  in  6  chroma qP (0..51); sampled with c00
VALID  out  1  YYOUT valid this cycle
YYOUT  out  16  signed dequantised DC; order d00, d01, d10, d11
READYO  in  1  downstream ready for the next output term

Behaviour:
- Reset (asynchronous assert) clears input counter icnt, output counter ocnt, busy, all pipeline valid bits, VALID=0 and YYOUT=0. Data registers are don't-care. A partial block is discarded. READYI=1 after reset.
- Input register stage: ENABLE, XXIN and QP are registered every cycle (enablei, xxii, qpi). All input logic acts on the registered copies.
- Input sequencing, on enablei=1 and !busy:
  - icnt 0: r0 = xxii; latch qpi (values >51 clamp to 51).
  - icnt 1: r0 = r0 + xxii; r1 = r0 - xxii.
  - icnt 2: r2 = xxii.
  - icnt 3: r2 = r2 + xxii; r3 = r2 - xxii; busy set.
  - icnt increments mod 4.
  - enablei while busy is ignored and does not advance icnt.
  - Row sums are 17-bit signed.
- Output sequencer: when busy and (READYO or (TOGETHER==1 and ocnt!=0)), stage A registers the 18-bit signed f:
  - ocnt 0: r0 + r2
  - ocnt 1: r1 + r3
  - ocnt 2: r0 - r2
  - ocnt 3: r1 - r3; busy cleared.
  - ocnt increments mod 4. Stage A valid is set only on these cycles.
- Dequant stage B (free-running, no stall): YYOUT = sat16(((f * v[qp%6]) << (qp/6)) >>> 1).
  - v = {10,11,13,14,16,18}.
  - qp/6 and qp%6 come from a LUT or compare chain on the latched qp.
  - The product is 23 bits; after the shift it is at least 31 bits signed.
  - The shift right is arithmetic (rounds toward -inf).
  - Saturate to [-32768, 32767].
  - VALID = stage A valid delayed 1 cycle. YYOUT holds its last value when VALID=0.
- Latency: the edge that samples ENABLE with c11 is N. busy is set at N+1, stage A fires at N+2 (if READYO), VALID=1 at N+3.
- READYI rises in the cycle after the ocnt=3 term is selected. A new block may start then; its c00 never corrupts the terms still in flight, because r*/qp are consumed by stage A before reload.
- READYO low stalls only the sequencer. Terms already in stage A/B still emerge.

Test Plan:
- Coeffs 4,0,0,0, QP=0, READYO=1 -> VALID 4 consecutive cycles starting N+3, YYOUT 20,20,20,20; READYI low N+1..N+4.
- Coeffs 1,2,3,4, QP=12 -> f = 10,-2,-4,0 -> YYOUT 200,-40,-80,0.
- Rounding/sign: coeffs 1,0,0,0, QP=1 -> 5,5,5,5; coeffs -1,0,0,0, QP=1 -> -6,-6,-6,-6.
- Saturation at QP=51:
  - Coeffs 32767 x4 -> 32767,0,0,0.
  - Coeffs -32768 x4 -> -32768,0,0,0.
- Backpressure (coeffs 1,2,3,4, QP=12), two runs:
  - TOGETHER=0, READYO dropped for 5 cycles after the first term -> 200 then gap then -40,-80,0 in order, no duplicates.
  - TOGETHER=1, same stimulus -> all 4 terms on consecutive VALID cycles.
- RESET pulsed after 2 coeffs, mid-cycle (async) -> VALID=0, YYOUT=0, READYI=1 immediately. The following block 4,0,0,0, QP=0 -> 20 x4, with no residue from the aborted block.
